// File: rtl/pipe_pkg.sv
// Pipeline stage bundle widths and packed layouts shared by every stage register.
// Stage instances pack/unpack through these types; pipe_stage_reg sees only bits.
package pipe_pkg;

    localparam int IDEX_W  = 197;
    localparam int EXMEM_W = 107;
    localparam int MEMWB_W = 71;

    // Field order is fixed: first field lands in the MSBs of the bus.
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] offset;
        logic        ctrl_branch;
        logic [3:0]  alu_op;
        logic [1:0]  shift_op;
        logic        alu_src_b;
        logic [2:0]  condition;
        logic [1:0]  load_type;
        logic        load_byte;
        logic        reg_wr;
        logic        mem_wr;
        logic        mem_to_reg;
        logic [31:0] pc;
        logic [31:0] target;
        logic [4:0]  shamt;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rt_val;
        logic [4:0]  rd;
        logic [1:0]  load_type;
        logic        load_byte;
        logic        reg_wr;
        logic        mem_wr;
        logic        mem_to_reg;
        logic [31:0] pc;
    } exmem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wb_data;
        logic        reg_wr;
        logic        mem_to_reg;
        logic [31:0] mem_data;
    } memwb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry stage register (main + skid) with registered in_ready and flush.
// State advances on the falling clock edge like the rest of the pipeline latches.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH          = IDEX_W,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = main_v_q & out_ready;

    always_comb begin
        main_v_d   = main_v_q;
        main_d_d   = main_d_q;
        skid_v_d   = skid_v_q;
        skid_d_d   = skid_d_q;
        if (flush) begin
            main_v_d = 1'b0;
            main_d_d = '0;
            skid_v_d = 1'b0;
            skid_d_d = '0;
        end else if (!main_v_q || emit) begin
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d_d = skid_d_q;
                skid_v_d = accept;
                if (accept) skid_d_d = in_data;
            end else if (accept) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end else begin
                // main_d is kept so a non-zeroing stage can hold the last payload
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
        end
        in_ready_d = !skid_v_d;
    end

    always_ff @(negedge clk) begin
        if (Reset) begin
            main_v_q   <= 1'b0;
            main_d_q   <= '0;
            skid_v_q   <= 1'b0;
            skid_d_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            main_v_q   <= main_v_d;
            main_d_q   <= main_d_d;
            skid_v_q   <= skid_v_d;
            skid_d_q   <= skid_d_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = (ZERO_ON_BUBBLE && !main_v_q) ? '0 : main_d_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule
